// File: rtl/acc_datapath_mc.sv
// acc_datapath_mc: parametrised multi-cycle accumulator datapath.
// Holds PC, IR, TR, DI, an accumulator file, A/B operand registers, the ALU
// result register and CZN flags. One micro-op runs per accepted command;
// memory is reached over a req/rdy handshake.
// Optional build macro: DP_ILLEGAL_OP_EN (ops 11-15 raise a sticky err flag).
module acc_datapath_mc #(
  parameter int DW   = 8,
  parameter int AW   = 13,
  parameter int NACC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [1:0]    cmd_acc_sel,
  input  logic [1:0]    cmd_alu_op,
  input  logic          cmd_a_zero,
  input  logic          cmd_b_zero,
  output logic          done,
  output logic          busy,
  output logic [DW-1:0] ir_out,
  output logic [AW-DW-1:0] di_out,
  output logic [2:0]    czn_out,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  localparam int IW  = $clog2(NACC);
  localparam int DIW = AW - DW;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEM  = 1'b1;

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_FETCH      = 4'd1;
  localparam logic [3:0] OP_FETCH_TR   = 4'd2;
  localparam logic [3:0] OP_LOAD_B_MEM = 4'd3;
  localparam logic [3:0] OP_LOAD_A     = 4'd4;
  localparam logic [3:0] OP_LOAD_B_ACC = 4'd5;
  localparam logic [3:0] OP_ALU        = 4'd6;
  localparam logic [3:0] OP_WR_ACC     = 4'd7;
  localparam logic [3:0] OP_STORE      = 4'd8;
  localparam logic [3:0] OP_JUMP       = 4'd9;
  localparam logic [3:0] OP_LD_DI      = 4'd10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_ADC = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [AW-1:0] PcOne = AW'(1);

  logic [0:0]    state;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [AW-1:0] tr;
  logic [DIW-1:0] di;
  logic [DW-1:0] accFile [NACC];
  logic [DW-1:0] regA;
  logic [DW-1:0] regB;
  logic [DW-1:0] res;
  logic          cFlag;
  logic          zFlag;
  logic          nFlag;
  logic          doneR;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [3:0]    pendOp;

  logic [IW-1:0] accIdx;
  logic [DW-1:0] aIn;
  logic [DW-1:0] bIn;
  logic [DW:0]   aluSum;
  logic          isMemOp;
  logic          accept;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == MEM);
  assign mem_req   = (state == MEM);
  assign mem_we    = memWe;
  assign mem_addr  = memAddr;
  assign mem_wdata = memWdata;
  assign done      = doneR;
  assign ir_out    = ir;
  assign di_out    = di;
  assign czn_out   = {nFlag, zFlag, cFlag};
  assign accept    = (state == IDLE) && cmd_valid;

  // Accumulator index, resolved from the IR/DI contents present at accept.
  always_comb begin
    accIdx = '0;
    case (cmd_acc_sel)
      2'd0:    accIdx = di[DIW-1 -: IW];
      2'd1:    accIdx = ir[IW-1:0];
      2'd2:    accIdx = ir[2*IW-1:IW];
      default: accIdx = '0;
    endcase
  end

  // Ops that leave IDLE and wait for the memory handshake.
  always_comb begin
    isMemOp = 1'b0;
    case (cmd_op)
      OP_FETCH, OP_FETCH_TR, OP_LOAD_B_MEM, OP_STORE: isMemOp = 1'b1;
      default:                                        isMemOp = 1'b0;
    endcase
  end

  // ALU: operand forcing then a DW+1 bit result whose top bit is the carry.
  always_comb begin
    aIn    = cmd_a_zero ? '0 : regA;
    bIn    = cmd_b_zero ? '0 : regB;
    aluSum = '0;
    case (cmd_alu_op)
      ALU_ADD: aluSum = {1'b0, aIn} + {1'b0, bIn};
      ALU_ADC: aluSum = {1'b0, aIn} + {1'b0, bIn} + {{DW{1'b0}}, cFlag};
      ALU_AND: aluSum = {1'b0, aIn & bIn};
      default: aluSum = {1'b0, ~aIn};
    endcase
  end

  // Control FSM, architectural registers and memory interface registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      tr       <= '0;
      di       <= '0;
      regA     <= '0;
      regB     <= '0;
      res      <= '0;
      cFlag    <= 1'b0;
      zFlag    <= 1'b0;
      nFlag    <= 1'b0;
      doneR    <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      pendOp   <= OP_NOP;
      for (int unsigned i = 0; i < NACC; i++) accFile[i] <= '0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pendOp <= cmd_op;
            doneR  <= !isMemOp;
            case (cmd_op)
              OP_FETCH, OP_FETCH_TR: begin
                memAddr <= pc;
                memWe   <= 1'b0;
                state   <= MEM;
              end
              OP_LOAD_B_MEM: begin
                memAddr <= tr;
                memWe   <= 1'b0;
                state   <= MEM;
              end
              OP_STORE: begin
                memAddr  <= tr;
                memWe    <= 1'b1;
                memWdata <= res;
                state    <= MEM;
              end
              OP_LOAD_A:     regA <= accFile[accIdx];
              OP_LOAD_B_ACC: regB <= accFile[accIdx];
              OP_ALU: begin
                res   <= aluSum[DW-1:0];
                cFlag <= aluSum[DW];
                zFlag <= (aluSum[DW-1:0] == '0);
                nFlag <= aluSum[DW-1];
              end
              OP_WR_ACC: accFile[accIdx] <= res;
              OP_JUMP:   pc <= tr;
              OP_LD_DI:  di <= ir[DIW-1:0];
              default: ;
            endcase
          end
        end
        MEM: begin
          if (mem_rdy) begin
            case (pendOp)
              OP_FETCH: begin
                ir <= mem_rdata;
                pc <= pc + PcOne;
              end
              OP_FETCH_TR: begin
                tr <= {ir[DIW-1:0], mem_rdata};
                pc <= pc + PcOne;
              end
              OP_LOAD_B_MEM: regB <= mem_rdata;
              default: ;
            endcase
            memWe <= 1'b0;
            doneR <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DP_ILLEGAL_OP_EN
  // Sticky illegal-op flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (accept && (cmd_op > OP_LD_DI)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_acc_datapath_mc.sv
// Scoreboard bench for acc_datapath_mc: a driver issues commands and updates
// a behavioural model, pushing expected memory requests and done-cycle
// register snapshots; a memory responder and a done monitor pop and compare.
module tb_acc_datapath_mc;
  localparam int DW    = 8;
  localparam int AW    = 13;
  localparam int NACC  = 4;
  localparam int IW    = 2;
  localparam int DIW   = AW - DW;
  localparam int MEMSZ = 1 << AW;
  localparam int DMASK = (1 << DW) - 1;
  localparam int AMASK = (1 << AW) - 1;
`ifdef DP_ILLEGAL_OP_EN
  localparam bit IllegalEn = 1'b1;
`else
  localparam bit IllegalEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_op = '0;
  logic [1:0] cmd_acc_sel = '0;
  logic [1:0] cmd_alu_op = '0;
  logic cmd_a_zero = 1'b0;
  logic cmd_b_zero = 1'b0;
  logic done, busy, err, mem_req, mem_we;
  logic [DW-1:0] ir_out;
  logic [DIW-1:0] di_out;
  logic [2:0] czn_out;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic mem_rdy = 1'b0;

  always #5 clk = ~clk;

  acc_datapath_mc #(.DW(DW), .AW(AW), .NACC(NACC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_acc_sel(cmd_acc_sel), .cmd_alu_op(cmd_alu_op),
    .cmd_a_zero(cmd_a_zero), .cmd_b_zero(cmd_b_zero), .done(done), .busy(busy),
    .ir_out(ir_out), .di_out(di_out), .czn_out(czn_out), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  int checkCnt = 0;
  int passCnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state
  int mPc, mIr, mTr, mDi, mA, mB, mRes, mC, mZ, mN, mErr;
  int mAcc [NACC];
  logic [7:0] refMem  [MEMSZ];
  logic [7:0] respMem [MEMSZ];

  typedef struct { bit we; int addr; int wdata; } memExp_t;
  typedef struct { int ir; int di; int czn; int err; int cyc; } doneExp_t;
  memExp_t  memQ[$];
  doneExp_t doneQ[$];
  int       delayQ[$];

  task automatic modelReset();
    mPc = 0; mIr = 0; mTr = 0; mDi = 0; mA = 0; mB = 0; mRes = 0;
    mC = 0; mZ = 0; mN = 0; mErr = 0;
    for (int i = 0; i < NACC; i++) mAcc[i] = 0;
  endtask

  task automatic preload(input int addr, input int val);
    refMem[addr]  = val[7:0];
    respMem[addr] = val[7:0];
  endtask

  task automatic issue(input int op, input int sel, input int alu,
                       input int az, input int bz, input int dly);
    int idx, ap, bp, s, lat;
    bit isMem;
    memExp_t me;
    doneExp_t de;
    for (int w = 0; w < 200 && !cmd_ready; w++) @(negedge clk);
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op[3:0]; cmd_acc_sel = sel[1:0];
    cmd_alu_op = alu[1:0]; cmd_a_zero = az[0]; cmd_b_zero = bz[0];
    case (sel)
      0:       idx = (mDi >> (DIW - IW)) % NACC;
      1:       idx = mIr % NACC;
      2:       idx = (mIr / NACC) % NACC;
      default: idx = 0;
    endcase
    isMem = (op == 1) || (op == 2) || (op == 3) || (op == 8);
    case (op)
      1: begin me = '{1'b0, mPc, 0}; mIr = refMem[mPc]; mPc = (mPc + 1) & AMASK; end
      2: begin
        me = '{1'b0, mPc, 0};
        mTr = ((mIr % (1 << DIW)) << DW) | refMem[mPc];
        mPc = (mPc + 1) & AMASK;
      end
      3: begin me = '{1'b0, mTr, 0}; mB = refMem[mTr]; end
      4: mA = mAcc[idx];
      5: mB = mAcc[idx];
      6: begin
        ap = az ? 0 : mA;
        bp = bz ? 0 : mB;
        case (alu)
          0:       s = ap + bp;
          1:       s = ap + bp + mC;
          2:       s = ap & bp;
          default: s = (~ap) & DMASK;
        endcase
        mRes = s & DMASK;
        mC = (s > DMASK) ? 1 : 0;
        mZ = (mRes == 0) ? 1 : 0;
        mN = (mRes >> (DW - 1)) & 1;
      end
      7: mAcc[idx] = mRes;
      8: begin me = '{1'b1, mTr, mRes}; refMem[mTr] = mRes[7:0]; end
      9: mPc = mTr;
      10: mDi = mIr % (1 << DIW);
      default: if (op > 10 && IllegalEn) mErr = 1;
    endcase
    lat = isMem ? (1 + dly) : 0;
    if (isMem) begin
      memQ.push_back(me);
      delayQ.push_back(dly);
    end
    de = '{mIr, mDi, (mN << 2) | (mZ << 1) | mC, mErr, cyc + 1 + lat};
    doneQ.push_back(de);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Memory responder: checks each request, holds mem_rdy low for the chosen
  // delay while checking stability, then completes the access.
  initial begin
    memExp_t e;
    int d;
    logic [AW-1:0] a0;
    logic w0;
    logic [DW-1:0] wd0;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        d = (delayQ.size() != 0) ? delayQ.pop_front() : 0;
        if (memQ.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          e = memQ.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
        chk("ready_in_mem", cmd_ready, 1'b0);
        chk("busy_in_mem", busy, 1'b1);
        a0 = mem_addr; w0 = mem_we; wd0 = mem_wdata;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (rst) break;
          chk("req_held", mem_req, 1'b1);
          chk("addr_held", mem_addr, a0);
          chk("we_held", mem_we, w0);
          if (w0) chk("wdata_held", mem_wdata, wd0);
          chk("ready_in_mem", cmd_ready, 1'b0);
        end
        if (!rst) begin
          if (w0) respMem[a0] = wd0;
          else mem_rdata = respMem[a0];
          mem_rdy = 1'b1;
          @(negedge clk);
          mem_rdy = 1'b0;
          mem_rdata = DW'($urandom);
        end
      end
    end
  end

  // Done monitor: each pulse must match the next expected snapshot and cycle.
  always @(negedge clk) begin
    doneExp_t e;
    if (!rst && done) begin
      if (doneQ.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = doneQ.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("ir_out", ir_out, e.ir);
        chk("di_out", di_out, e.di);
        chk("czn_out", czn_out, e.czn);
        chk("err", err, e.err);
      end
    end
  end

  initial begin
    for (int i = 0; i < MEMSZ; i++) preload(i, $urandom % 256);
    modelReset();
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ir", ir_out, 0);
    chk("rst_di", di_out, 0);
    chk("rst_czn", czn_out, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);

    // Directed sequence
    preload(mPc, 'hA5); issue(1, 3, 0, 0, 0, 0);      // IR=A5, PC=1
    preload(mPc, 'h1F); issue(1, 3, 0, 0, 0, 0);      // IR=1F
    preload(mPc, 'h34); issue(2, 3, 0, 0, 0, 3);      // TR=1F34, slow memory
    preload(mTr, 'hF0); issue(3, 3, 0, 0, 0, 1);      // B=F0
    issue(6, 3, 0, 1, 0, 0);                          // RES=F0
    issue(7, 3, 0, 0, 0, 0);                          // acc0=F0
    issue(4, 3, 0, 0, 0, 0);                          // A=F0
    preload(mTr, 'h20); issue(3, 3, 0, 0, 0, 0);      // B=20
    issue(6, 3, 0, 0, 0, 0);                          // ADD -> 10, C=1
    issue(6, 3, 1, 0, 1, 0);                          // ADC B'=0 -> F1, N=1
    issue(7, 1, 0, 0, 0, 0);                          // acc3=F1
    issue(8, 3, 0, 0, 0, 2);                          // STORE F1 to 1F34
    preload(mPc, 'hFF); issue(2, 3, 0, 0, 0, 0);      // TR=1FFF
    issue(9, 3, 0, 0, 0, 0);                          // PC=1FFF
    preload(mPc, 'h0A); issue(1, 3, 0, 0, 0, 0);      // fetch at 1FFF, PC wraps
    preload(mPc, 'h0A); issue(1, 3, 0, 0, 0, 0);      // fetch at 0
    preload(mPc, 'hBC); issue(2, 3, 0, 0, 0, 0);      // TR=0ABC
    issue(9, 3, 0, 0, 0, 0);                          // PC=0ABC
    issue(1, 3, 0, 0, 0, 1);                          // fetch at 0ABC
    issue(10, 3, 0, 0, 0, 0);                         // DI=IR[4:0]
    issue(5, 0, 0, 0, 0, 0);                          // B=acc[DI[4:3]]
    issue(12, 3, 0, 0, 0, 0);                         // illegal op
    issue(4, 2, 0, 0, 0, 0);

    // Randomised traffic
    repeat (300) issue($urandom % 16, $urandom % 4, $urandom % 4,
                       ($urandom % 4) == 0, ($urandom % 4) == 0, $urandom % 4);

    for (int w = 0; w < 100 && doneQ.size() != 0; w++) @(negedge clk);
    chk("drain_done", doneQ.size(), 0);
    chk("drain_mem", memQ.size(), 0);

    // Reset in the middle of a memory access
    for (int w = 0; w < 100 && !cmd_ready; w++) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_acc_sel = 2'd3;
    memQ.push_back('{1'b0, mPc, 0});
    delayQ.push_back(8);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", mem_req, 1'b0);
    chk("midrst_we", mem_we, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ir", ir_out, 0);
    chk("midrst_czn", czn_out, 0);
    chk("midrst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    doneQ.delete();
    preload(0, 'h5A); issue(1, 3, 0, 0, 0, 0);        // PC back to 0
    for (int w = 0; w < 100 && doneQ.size() != 0; w++) @(negedge clk);
    chk("final_drain", doneQ.size(), 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
